// File: rtl/ms_pkg.sv
// Shared constants and cell-geometry helpers for the 8x8 minesweeper neighbourhood engine.
// Cell index i = y*8 + x, with x and y in 0..7.
package ms_pkg;

    localparam int MS_W     = 8;
    localparam int MS_H     = 8;
    localparam int MS_CELLS = MS_W * MS_H;
    localparam int MS_CNT_W = 4;

    function automatic int ms_idx(input int x, input int y);
        return y * MS_W + x;
    endfunction

    // True when (x+dx, y+dy) is an on-board neighbour of (x, y); the cell itself is excluded.
    // There is no wrap at the board edges.
    function automatic logic ms_nbr_valid(input int x, input int y, input int dx, input int dy);
        int nx;
        int ny;
        nx = x + dx;
        ny = y + dy;
        return !(dx == 0 && dy == 0) && (nx >= 0) && (nx < MS_W) && (ny >= 0) && (ny < MS_H);
    endfunction

endpackage

// File: rtl/ms_round_check.sv
// One reveal round, purely combinational.
// A cell is marked when it is already open, or when any on-board neighbour is both open and
// a zero cell.
// Ports:
//   is_zero [63:0] in   zero-cell mask computed from the same inputs as open
//   open    [63:0] in   currently opened cells
//   check   [63:0] out  cells open after one reveal round
module ms_round_check
    import ms_pkg::*;
(
    input  logic [MS_CELLS-1:0] is_zero,
    input  logic [MS_CELLS-1:0] open,
    output logic [MS_CELLS-1:0] check
);

    // Open zero cells spread to their neighbours.
    logic [MS_CELLS-1:0] w_src;
    assign w_src = is_zero & open;

    for (genvar gy = 0; gy < MS_H; gy++) begin : g_row
        for (genvar gx = 0; gx < MS_W; gx++) begin : g_col
            localparam int IDX = ms_idx(gx, gy);

            // 3x3 window, bit = dy*3 + dx; centre and off-board positions tie to 0.
            logic [8:0] w_nb;

            for (genvar gdy = 0; gdy < 3; gdy++) begin : g_dy
                for (genvar gdx = 0; gdx < 3; gdx++) begin : g_dx
                    if (ms_nbr_valid(gx, gy, gdx - 1, gdy - 1)) begin : g_on
                        assign w_nb[gdy*3+gdx] = w_src[ms_idx(gx + gdx - 1, gy + gdy - 1)];
                    end else begin : g_off
                        assign w_nb[gdy*3+gdx] = 1'b0;
                    end
                end
            end

            assign check[IDX] = open[IDX] | (|w_nb);
        end
    end

endmodule

// File: rtl/ms_round.sv
// Minesweeper neighbourhood engine for an 8x8 board.
// Computes per-cell adjacent-mine counts, the zero-cell mask and one reveal round, all
// registered with one cycle of latency.
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset, clears all outputs
//   mine      [63:0]  in   mine map, bit i = cell (i%8, i/8)
//   open      [63:0]  in   currently opened cells
//   count_flat[255:0] out  bit-plane counts {plane0 (LSB), plane1, plane2, plane3 (MSB)}
//   is_zero   [63:0]  out  cell is not a mine and has no adjacent mines
//   check     [63:0]  out  cells open after one reveal round
module ms_round
    import ms_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [MS_CELLS-1:0]          mine,
    input  logic [MS_CELLS-1:0]          open,
    output logic [MS_CELLS*MS_CNT_W-1:0] count_flat,
    output logic [MS_CELLS-1:0]          is_zero,
    output logic [MS_CELLS-1:0]          check
);

    logic [MS_CELLS*MS_CNT_W-1:0] w_count_flat;
    logic [MS_CELLS-1:0]          w_is_zero;
    logic [MS_CELLS-1:0]          w_check;

    logic [MS_CELLS*MS_CNT_W-1:0] r_count_flat;
    logic [MS_CELLS-1:0]          r_is_zero;
    logic [MS_CELLS-1:0]          r_check;

    for (genvar gy = 0; gy < MS_H; gy++) begin : g_row
        for (genvar gx = 0; gx < MS_W; gx++) begin : g_col
            localparam int IDX = ms_idx(gx, gy);

            // 3x3 window of neighbour mines, bit = dy*3 + dx; the cell's own mine is excluded.
            logic [8:0]          w_nb;
            logic [MS_CNT_W-1:0] w_cnt;

            for (genvar gdy = 0; gdy < 3; gdy++) begin : g_dy
                for (genvar gdx = 0; gdx < 3; gdx++) begin : g_dx
                    if (ms_nbr_valid(gx, gy, gdx - 1, gdy - 1)) begin : g_on
                        assign w_nb[gdy*3+gdx] = mine[ms_idx(gx + gdx - 1, gy + gdy - 1)];
                    end else begin : g_off
                        assign w_nb[gdy*3+gdx] = 1'b0;
                    end
                end
            end

            assign w_cnt = {3'b000, w_nb[0]} + {3'b000, w_nb[1]} + {3'b000, w_nb[2]}
                         + {3'b000, w_nb[3]} + {3'b000, w_nb[4]} + {3'b000, w_nb[5]}
                         + {3'b000, w_nb[6]} + {3'b000, w_nb[7]} + {3'b000, w_nb[8]};

            // Plane K holds bit K of every count; plane0 sits in the top 64 bits.
            assign w_count_flat[3*MS_CELLS+IDX] = w_cnt[0];
            assign w_count_flat[2*MS_CELLS+IDX] = w_cnt[1];
            assign w_count_flat[1*MS_CELLS+IDX] = w_cnt[2];
            assign w_count_flat[0*MS_CELLS+IDX] = w_cnt[3];

            assign w_is_zero[IDX] = ~mine[IDX] & (w_cnt == '0);
        end
    end

    // Fed with the combinational zero mask so check and is_zero stay coherent.
    ms_round_check u_check (
        .is_zero (w_is_zero),
        .open    (open),
        .check   (w_check)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count_flat <= '0;
            r_is_zero    <= '0;
            r_check      <= '0;
        end else begin
            r_count_flat <= w_count_flat;
            r_is_zero    <= w_is_zero;
            r_check      <= w_check;
        end
    end

    assign count_flat = r_count_flat;
    assign is_zero    = r_is_zero;
    assign check      = r_check;

endmodule

// File: tb/tb_ms_round.sv
module tb_ms_round;

    logic         clk;
    logic         rst_n;
    logic [63:0]  mine;
    logic [63:0]  open;
    logic [255:0] count_flat;
    logic [63:0]  is_zero;
    logic [63:0]  check;

    typedef struct packed {
        logic [255:0] cf;
        logic [63:0]  iz;
        logic [63:0]  ck;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    ms_round dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mine       (mine),
        .open       (open),
        .count_flat (count_flat),
        .is_zero    (is_zero),
        .check      (check)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] cnt_of(input logic [255:0] f, input int i);
        return {f[i], f[64+i], f[128+i], f[192+i]};
    endfunction

    // Reference: direct neighbour scan with explicit bounds.
    function automatic exp_t model(input logic [63:0] m, input logic [63:0] o);
        exp_t        e;
        logic [63:0] z;
        logic [3:0]  c;
        int          nx;
        int          ny;
        e = '0;
        z = '0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                c = 4'd0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        nx = x + dx;
                        ny = y + dy;
                        if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8 && ny >= 0 && ny < 8)
                            c = c + {3'b000, m[ny*8+nx]};
                    end
                end
                e.cf[192+y*8+x] = c[0];
                e.cf[128+y*8+x] = c[1];
                e.cf[64+y*8+x]  = c[2];
                e.cf[y*8+x]     = c[3];
                z[y*8+x] = !m[y*8+x] && (c == 4'd0);
            end
        end
        e.iz = z;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                e.ck[y*8+x] = o[y*8+x];
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        nx = x + dx;
                        ny = y + dy;
                        if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8 && ny >= 0 && ny < 8)
                            if (o[ny*8+nx] && z[ny*8+nx]) e.ck[y*8+x] = 1'b1;
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic drive(input logic [63:0] m, input logic [63:0] o);
        @(negedge clk);
        mine = m;
        open = o;
        sb_q.push_back(model(m, o));
    endtask

    // Wait until the result of the last drive is visible on the outputs.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("sb_count_flat", count_flat, e.cf);
                check_eq("sb_is_zero", 256'(is_zero), 256'(e.iz));
                check_eq("sb_check", 256'(check), 256'(e.ck));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        mine     = {$urandom(), $urandom()};
        open     = {$urandom(), $urandom()};
        repeat (3) @(negedge clk);
        check_eq("rst_count_flat", count_flat, 256'd0);
        check_eq("rst_is_zero", 256'(is_zero), 256'd0);
        check_eq("rst_check", 256'(check), 256'd0);
        rst_n = 1'b1;

        // Empty board.
        drive(64'd0, 64'd0);
        settle();
        check_eq("t2_count_flat", count_flat, 256'd0);
        check_eq("t2_is_zero", 256'(is_zero), 256'hFFFF_FFFF_FFFF_FFFF);
        check_eq("t2_check", 256'(check), 256'd0);

        // Border ring plus cell 36.
        drive(64'hFF81_8191_8181_81FF, 64'd0);
        settle();
        check_eq("t3_cnt0", 256'(cnt_of(count_flat, 0)), 256'd2);
        check_eq("t3_cnt9", 256'(cnt_of(count_flat, 9)), 256'd5);
        check_eq("t3_cnt27", 256'(cnt_of(count_flat, 27)), 256'd1);
        check_eq("t3_cnt18", 256'(cnt_of(count_flat, 18)), 256'd0);
        check_eq("t3_iz18", 256'(is_zero[18]), 256'd1);
        check_eq("t3_iz27", 256'(is_zero[27]), 256'd0);
        check_eq("t3_iz0", 256'(is_zero[0]), 256'd0);

        // Corner mine, open cell 3 spreads to cells 2,4,10,11,12.
        drive(64'h1, 64'h8);
        settle();
        check_eq("t4_cnt1", 256'(cnt_of(count_flat, 1)), 256'd1);
        check_eq("t4_cnt8", 256'(cnt_of(count_flat, 8)), 256'd1);
        check_eq("t4_cnt9", 256'(cnt_of(count_flat, 9)), 256'd1);
        check_eq("t4_cnt0", 256'(cnt_of(count_flat, 0)), 256'd0);
        check_eq("t4_is_zero", 256'(is_zero), 256'hFFFF_FFFF_FFFF_FCFC);
        check_eq("t4_check", 256'(check), 256'h1C1C);

        // Full board of mines: maximum counts, no zero cells.
        drive({64{1'b1}}, 64'd0);
        settle();
        check_eq("t5_cnt0", 256'(cnt_of(count_flat, 0)), 256'd3);
        check_eq("t5_cnt1", 256'(cnt_of(count_flat, 1)), 256'd5);
        check_eq("t5_cnt9", 256'(cnt_of(count_flat, 9)), 256'd8);
        check_eq("t5_plane3_b9", 256'(count_flat[9]), 256'd1);
        check_eq("t5_is_zero", 256'(is_zero), 256'd0);

        // No wrap from x=7 into the next row; open cell 8 spreads to 0,1,9,16,17.
        drive(64'h80, 64'h100);
        settle();
        check_eq("t6_cnt8", 256'(cnt_of(count_flat, 8)), 256'd0);
        check_eq("t6_iz8", 256'(is_zero[8]), 256'd1);
        check_eq("t6_check", 256'(check), 256'h3_0303);

        // Back-to-back random traffic, sparse and dense.
        for (int k = 0; k < 150; k++) begin
            logic [63:0] m;
            logic [63:0] o;
            m = {$urandom(), $urandom()};
            if (k % 2 == 0) m = m & {$urandom(), $urandom()} & {$urandom(), $urandom()};
            o = {$urandom(), $urandom()} & {$urandom(), $urandom()};
            drive(m, o);
        end

        // Asynchronous reset mid-operation.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check_eq("mid_rst_count_flat", count_flat, 256'd0);
        check_eq("mid_rst_is_zero", 256'(is_zero), 256'd0);
        check_eq("mid_rst_check", 256'(check), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(64'h1, 64'h8);
        settle();
        check_eq("post_rst_check", 256'(check), 256'h1C1C);

        repeat (3) @(negedge clk);
        check_eq("sb_drain", 256'(sb_q.size()), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
